fb_rect_fill: RTL and testbench

Rectangle-fill draw engine sitting directly upstream of the VGA controller's framebuffer. It accepts a fill command (origin, size, 3-bit color), clips it to the visible frame, and writes one pixel per granted cycle into the framebuffer through a request/acknowledge write port. That port is arbitrated against the VGA scan-out reads. The resulting 18-bit framebuffer addresses and 3-bit colors are exactly what the VGA controller later fetches and drives onto its `color` output.

---
 rtl/fb_rect_fill_if.sv | 30 +++
 rtl/fb_rect_fill.sv | 192 +++++++++++++++++++
 tb/tb_fb_rect_fill.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fb_rect_fill_if.sv
// -----------------------------------------------------------------------------
// fb_rect_fill_if
// Framebuffer write port between the rectangle-fill engine and the
// framebuffer arbiter.
//   wr_req  : write request, held until granted
//   wr_addr : 18-bit pixel address (y*H_RES + x)
//   wr_data : 3-bit {r,g,b} color
//   wr_ack  : grant; a write completes on any edge with wr_req && wr_ack
// master = fill engine, slave = arbiter / framebuffer side.
// -----------------------------------------------------------------------------
interface fb_rect_fill_if;
  logic        wr_req;
  logic [17:0] wr_addr;
  logic [2:0]  wr_data;
  logic        wr_ack;

  modport master (
    output wr_req,
    output wr_addr,
    output wr_data,
    input  wr_ack
  );

  modport slave (
    input  wr_req,
    input  wr_addr,
    input  wr_data,
    output wr_ack
  );
endinterface

// File: rtl/fb_rect_fill.sv
// -----------------------------------------------------------------------------
// fb_rect_fill
// Rectangle-fill draw engine feeding the VGA framebuffer. Accepts a fill
// command, clips it to the visible H_RES x V_RES frame and writes one pixel
// per granted cycle, row-major, through a request/acknowledge write port.
//
// Ports
//   clk, resetn        : system clock, asynchronous active-low reset
//   start              : command strobe, only sampled while idle
//   x0, y0             : top-left corner of the rectangle
//   width, height      : rectangle size in pixels / lines
//   fill_color         : {r,g,b} color written to every pixel
//   busy               : command in progress (start ignored)
//   done               : one-cycle pulse when a command completes
//   wr                 : framebuffer write port (master side)
// -----------------------------------------------------------------------------
module fb_rect_fill #(
  parameter int H_RES = 640,
  parameter int V_RES = 400
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  start,
  input  logic [9:0]            x0,
  input  logic [8:0]            y0,
  input  logic [9:0]            width,
  input  logic [8:0]            height,
  input  logic [2:0]            fill_color,
  output logic                  busy,
  output logic                  done,
  fb_rect_fill_if.master        wr
);

  localparam logic [10:0] H_LIMIT  = 11'(H_RES);
  localparam logic [9:0]  V_LIMIT  = 10'(V_RES);
  localparam logic [17:0] H_STRIDE = 18'(H_RES);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CLIP,
    ST_WRITE,
    ST_DONE
  } state_t;

  state_t      state_reg;

  // latched command
  logic [9:0]  x0_reg;
  logic [8:0]  y0_reg;
  logic [9:0]  width_reg;
  logic [8:0]  height_reg;
  logic [2:0]  color_reg;

  // walk state (exclusive end bounds after clipping)
  logic [10:0] x_end_reg;
  logic [9:0]  y_end_reg;
  logic [9:0]  x_reg;
  logic [8:0]  y_reg;
  logic [17:0] row_base_reg;

  // registered outputs
  logic        busy_reg;
  logic        done_reg;
  logic        wr_req_reg;
  logic [17:0] wr_addr_reg;
  logic [2:0]  wr_data_reg;

  // ---------------------------------------------------------------------------
  // Clipping, evaluated during CLIP from the latched command. One extra bit
  // on each sum keeps x0+width / y0+height from wrapping.
  // ---------------------------------------------------------------------------
  logic [10:0] x_sum;
  logic [9:0]  y_sum;
  logic [10:0] x_end_clip;
  logic [9:0]  y_end_clip;
  logic        empty_cmd;
  logic [17:0] row_base_init;

  assign x_sum         = {1'b0, x0_reg} + {1'b0, width_reg};
  assign y_sum         = {1'b0, y0_reg} + {1'b0, height_reg};
  assign x_end_clip    = (x_sum > H_LIMIT) ? H_LIMIT : x_sum;
  assign y_end_clip    = (y_sum > V_LIMIT) ? V_LIMIT : y_sum;
  assign empty_cmd     = (width_reg == 10'd0) || (height_reg == 9'd0) ||
                         ({1'b0, x0_reg} >= H_LIMIT) ||
                         ({1'b0, y0_reg} >= V_LIMIT);
  assign row_base_init = 18'(y0_reg) * H_STRIDE;

  // ---------------------------------------------------------------------------
  // Walk decisions for the pixel currently on the bus. The next address is
  // precomputed here so a granted write can be followed by the next pixel on
  // the very next cycle, including across a row wrap.
  // ---------------------------------------------------------------------------
  logic        last_col;
  logic        last_row;
  logic [17:0] next_row_base;

  assign last_col      = ({1'b0, x_reg} + 11'd1) >= x_end_reg;
  assign last_row      = ({1'b0, y_reg} + 10'd1) >= y_end_reg;
  assign next_row_base = row_base_reg + H_STRIDE;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg    <= ST_IDLE;
      x0_reg       <= '0;
      y0_reg       <= '0;
      width_reg    <= '0;
      height_reg   <= '0;
      color_reg    <= '0;
      x_end_reg    <= '0;
      y_end_reg    <= '0;
      x_reg        <= '0;
      y_reg        <= '0;
      row_base_reg <= '0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      wr_req_reg   <= 1'b0;
      wr_addr_reg  <= '0;
      wr_data_reg  <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          done_reg <= 1'b0;
          if (start) begin
            x0_reg     <= x0;
            y0_reg     <= y0;
            width_reg  <= width;
            height_reg <= height;
            color_reg  <= fill_color;
            busy_reg   <= 1'b1;
            state_reg  <= ST_CLIP;
          end
        end

        ST_CLIP: begin
          x_end_reg <= x_end_clip;
          y_end_reg <= y_end_clip;
          if (empty_cmd) begin
            done_reg  <= 1'b1;
            state_reg <= ST_DONE;
          end else begin
            x_reg        <= x0_reg;
            y_reg        <= y0_reg;
            row_base_reg <= row_base_init;
            wr_req_reg   <= 1'b1;
            wr_addr_reg  <= row_base_init + 18'(x0_reg);
            wr_data_reg  <= color_reg;
            state_reg    <= ST_WRITE;
          end
        end

        ST_WRITE: begin
          // Without a grant everything holds, so address/data stay stable.
          if (wr.wr_ack) begin
            if (!last_col) begin
              x_reg       <= x_reg + 10'd1;
              wr_addr_reg <= wr_addr_reg + 18'd1;
            end else if (!last_row) begin
              x_reg        <= x0_reg;
              y_reg        <= y_reg + 9'd1;
              row_base_reg <= next_row_base;
              wr_addr_reg  <= next_row_base + 18'(x0_reg);
            end else begin
              wr_req_reg <= 1'b0;
              done_reg   <= 1'b1;
              state_reg  <= ST_DONE;
            end
          end
        end

        ST_DONE: begin
          done_reg  <= 1'b0;
          busy_reg  <= 1'b0;
          state_reg <= ST_IDLE;
        end

        default: begin
          state_reg  <= ST_IDLE;
          busy_reg   <= 1'b0;
          done_reg   <= 1'b0;
          wr_req_reg <= 1'b0;
        end
      endcase
    end
  end

  assign busy       = busy_reg;
  assign done       = done_reg;
  assign wr.wr_req  = wr_req_reg;
  assign wr.wr_addr = wr_addr_reg;
  assign wr.wr_data = wr_data_reg;

endmodule

// File: tb/tb_fb_rect_fill.sv
// -----------------------------------------------------------------------------
// tb_fb_rect_fill
// Self-checking bench for fb_rect_fill. A directed table of commands with
// hand-derived results, a few hand-written multi-cycle sequences (start while
// busy, reset mid-command) and a randomized set of commands with random
// grant patterns. Every command is also checked against a reference model
// that enumerates the clipped rectangle directly and derives the timing from
// the grant pattern.
// -----------------------------------------------------------------------------
module tb_fb_rect_fill;

  localparam int H_RES = 640;
  localparam int V_RES = 400;
  localparam int LIMIT = 2000;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       start = 1'b0;
  logic [9:0] x0 = '0;
  logic [8:0] y0 = '0;
  logic [9:0] width = '0;
  logic [8:0] height = '0;
  logic [2:0] fill_color = '0;
  logic       busy;
  logic       done;

  fb_rect_fill_if bus ();

  fb_rect_fill #(
    .H_RES(H_RES),
    .V_RES(V_RES)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .start      (start),
    .x0         (x0),
    .y0         (y0),
    .width      (width),
    .height     (height),
    .fill_color (fill_color),
    .busy       (busy),
    .done       (done),
    .wr         (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int x0;
    int y0;
    int w;
    int h;
    int color;
    int mode;       // 0: ack tied high, 1: ack low in cycles 2..4, 2: random
    int exp_n;
    int exp_first;
    int exp_last;
    int exp_done;
  } vec_t;

  int n_vec = 0;
  int n_mis = 0;

  int got_addr[$];
  int got_data[$];
  int got_cyc[$];
  int done_cyc[$];
  int exp_addr[$];
  bit ack_pat[0:LIMIT];

  task automatic check(input string name, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_mis++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // Reference: every visible pixel of the rectangle, row-major.
  function automatic void model(input int cx0, input int cy0, input int cw, input int ch);
    int xe;
    int ye;
    exp_addr.delete();
    xe = (cx0 + cw < H_RES) ? cx0 + cw : H_RES;
    ye = (cy0 + ch < V_RES) ? cy0 + ch : V_RES;
    for (int y = cy0; y < ye; y++)
      for (int x = cx0; x < xe; x++)
        exp_addr.push_back(y * H_RES + x);
  endfunction

  // Issues one command (entered and left at #1 after a rising edge). Cycle 0
  // is the edge that samples start; cycle k is the period after edge k.
  task automatic run_cmd(input int cx0, input int cy0, input int cw, input int ch,
                         input int cc, input int mode, input int second_at,
                         output int n_got, output int first_a, output int last_a,
                         output int done_c);
    int   busy_low;
    int   hold_viol;
    int   req_cycles;
    int   exp_cyc[$];
    int   exp_done;
    int   n;
    logic p_req;
    logic p_ack;
    logic [17:0] p_addr;
    logic [2:0]  p_data;

    got_addr.delete(); got_data.delete(); got_cyc.delete(); done_cyc.delete();
    for (int c = 0; c <= LIMIT; c++) begin
      case (mode)
        0:       ack_pat[c] = 1'b1;
        1:       ack_pat[c] = !(c >= 2 && c <= 4);
        default: ack_pat[c] = ($urandom_range(0, 3) != 0);
      endcase
    end

    x0 = 10'(cx0); y0 = 9'(cy0); width = 10'(cw); height = 9'(ch);
    fill_color = 3'(cc);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;

    busy_low = -1; hold_viol = 0; req_cycles = 0;
    p_req = 1'b0; p_ack = 1'b0; p_addr = '0; p_data = '0;
    for (int c = 1; c < LIMIT; c++) begin
      bus.wr_ack = ack_pat[c];
      if (c == second_at) begin
        start = 1'b1; x0 = 10'd100; y0 = 9'd100; width = 10'd3; height = 9'd3;
        fill_color = 3'(~cc);
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      if (bus.wr_req) req_cycles++;
      if (p_req && !p_ack &&
          (!bus.wr_req || bus.wr_addr != p_addr || bus.wr_data != p_data))
        hold_viol++;
      if (bus.wr_req && bus.wr_ack) begin
        got_addr.push_back(int'(bus.wr_addr));
        got_data.push_back(int'(bus.wr_data));
        got_cyc.push_back(c);
      end
      if (done) done_cyc.push_back(c);
      p_req = bus.wr_req; p_ack = bus.wr_ack; p_addr = bus.wr_addr; p_data = bus.wr_data;
      if (!busy) begin
        busy_low = c;
        break;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    bus.wr_ack = 1'b0;

    if (busy_low < 0) check("timeout_busy_never_low", 1, 0);

    // Expected timing: the k-th write lands on the k-th granted cycle >= 2.
    model(cx0, cy0, cw, ch);
    n = exp_addr.size();
    for (int c = 2; c < LIMIT && exp_cyc.size() < n; c++)
      if (ack_pat[c]) exp_cyc.push_back(c);
    if (n == 0) exp_done = 2;
    else if (exp_cyc.size() == n) exp_done = exp_cyc[n-1] + 1;
    else exp_done = -1;

    check("num_writes", got_addr.size(), n);
    for (int i = 0; i < n && i < got_addr.size(); i++) begin
      check($sformatf("wr_addr[%0d]", i), got_addr[i], exp_addr[i]);
      check($sformatf("wr_data[%0d]", i), got_data[i], cc);
      check($sformatf("wr_cycle[%0d]", i), got_cyc[i], exp_cyc[i]);
    end
    check("done_pulses", done_cyc.size(), 1);
    done_c = (done_cyc.size() > 0) ? done_cyc[0] : -1;
    check("done_cycle", done_c, exp_done);
    check("busy_low_cycle", busy_low, exp_done + 1);
    check("hold_stable", hold_viol, 0);
    check("req_cycles", req_cycles, (n == 0) ? 0 : exp_done - 2);

    // Nothing may restart by itself once idle.
    repeat (3) @(negedge clk);
    check("idle_busy", int'(busy), 0);
    check("idle_req", int'(bus.wr_req), 0);
    @(posedge clk); #1;

    n_got   = got_addr.size();
    first_a = (n_got > 0) ? got_addr[0] : -1;
    last_a  = (n_got > 0) ? got_addr[n_got-1] : -1;
    $display("cmd x0=%0d y0=%0d w=%0d h=%0d c=%0d mode=%0d: %0d writes, done@%0d",
             cx0, cy0, cw, ch, cc, mode, n_got, done_c);
  endtask

  vec_t tbl[12];
  int   g_n, g_first, g_last, g_done;

  initial begin
    tbl[0]  = '{1,   1,   2,    2, 5, 0, 4,   641,    1282,   6};
    tbl[1]  = '{1,   1,   2,    2, 5, 1, 4,   641,    1282,   9};
    tbl[2]  = '{638, 399, 4,    2, 7, 0, 2,   255998, 255999, 4};
    tbl[3]  = '{5,   5,   0,    3, 1, 0, 0,   -1,     -1,     2};
    tbl[4]  = '{640, 0,   5,    5, 2, 0, 0,   -1,     -1,     2};
    tbl[5]  = '{3,   3,   4,    0, 4, 0, 0,   -1,     -1,     2};
    tbl[6]  = '{0,   400, 4,    4, 6, 0, 0,   -1,     -1,     2};
    tbl[7]  = '{0,   0,   1,    1, 3, 0, 1,   0,      0,      3};
    tbl[8]  = '{637, 10,  5,    3, 4, 1, 9,   7037,   8319,   14};
    tbl[9]  = '{0,   399, 640,  1, 6, 0, 640, 255360, 255999, 642};
    tbl[10] = '{0,   511, 2,    2, 1, 0, 0,   -1,     -1,     2};
    tbl[11] = '{600, 5,   1023, 1, 2, 0, 40,  3800,   3839,   42};

    bus.wr_ack = 1'b0;
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_req", int'(bus.wr_req), 0);
    check("reset_addr", int'(bus.wr_addr), 0);
    check("reset_data", int'(bus.wr_data), 0);
    resetn = 1'b1;
    @(posedge clk); #1;

    // Directed table
    foreach (tbl[i]) begin
      run_cmd(tbl[i].x0, tbl[i].y0, tbl[i].w, tbl[i].h, tbl[i].color, tbl[i].mode, -1,
              g_n, g_first, g_last, g_done);
      check($sformatf("tbl%0d_n", i), g_n, tbl[i].exp_n);
      check($sformatf("tbl%0d_first", i), g_first, tbl[i].exp_first);
      check($sformatf("tbl%0d_last", i), g_last, tbl[i].exp_last);
      check($sformatf("tbl%0d_done", i), g_done, tbl[i].exp_done);
    end

    // Start while busy: a second start in cycle 3 must be dropped.
    run_cmd(1, 1, 2, 2, 5, 0, 3, g_n, g_first, g_last, g_done);
    check("sbusy_n", g_n, 4);
    check("sbusy_last", g_last, 1282);
    check("sbusy_done", g_done, 6);

    // Reset during the second write of the basic fill.
    x0 = 10'd1; y0 = 9'd1; width = 10'd2; height = 9'd2; fill_color = 3'd5;
    bus.wr_ack = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;           // cycle 1
    start = 1'b0;
    @(posedge clk); #1;           // cycle 2
    @(posedge clk); #1;           // cycle 3: second write on the bus
    check("rst_mid_req_before", int'(bus.wr_req), 1);
    check("rst_mid_addr_before", int'(bus.wr_addr), 642);
    #2 resetn = 1'b0;
    #1;
    check("rst_async_req", int'(bus.wr_req), 0);
    check("rst_async_busy", int'(busy), 0);
    check("rst_async_done", int'(done), 0);
    check("rst_async_addr", int'(bus.wr_addr), 0);
    @(posedge clk); #1;
    resetn = 1'b1;
    bus.wr_ack = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("rst_no_done", int'(done), 0);
      check("rst_no_busy", int'(busy), 0);
    end
    @(posedge clk); #1;
    run_cmd(1, 1, 2, 2, 5, 0, -1, g_n, g_first, g_last, g_done);
    check("post_rst_n", g_n, 4);
    check("post_rst_first", g_first, 641);
    check("post_rst_done", g_done, 6);

    // Randomized commands with random grant patterns, concentrated near edges
    for (int k = 0; k < 30; k++) begin
      int rx0, ry0, rw, rh, rc;
      rx0 = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 639)) : int'($urandom_range(630, 700));
      ry0 = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 399)) : int'($urandom_range(392, 420));
      rw  = int'($urandom_range(0, 9));
      rh  = int'($urandom_range(0, 4));
      rc  = int'($urandom_range(0, 7));
      run_cmd(rx0, ry0, rw, rh, rc, 2, -1, g_n, g_first, g_last, g_done);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
